// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the receiver state encoding and frame data width.
package uart_pkg;

    localparam int DataBits = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } uart_rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Reset value is a parameter so idle-high lines can reset to 1.
module sync_2ff #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling.
// Define UART_RX_PARITY_EN for 8E1 frames with even-parity checking.
module uart_rx
    import uart_pkg::*;
#(
    parameter int TicksPerBaud = 104
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       rx_stb_o,
    output logic [7:0] rx_data_o,
    output logic       rx_err_o
);

    localparam int CntW = $clog2(TicksPerBaud);
    localparam logic [CntW-1:0] HalfLast = CntW'(TicksPerBaud / 2 - 1);
    localparam logic [CntW-1:0] BaudLast = CntW'(TicksPerBaud - 1);
    localparam logic [2:0] IdxLast = 3'(DataBits - 1);

    logic rx_s;

    uart_rx_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic stb_q, stb_d;
    logic err_q, err_d;
`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
`endif

    sync_2ff #(
        .ResetVal(1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Frame sequencing: start qualify, data shift, stop check
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        stb_d   = 1'b0;
        err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            StData: begin
                if (cnt_q == BaudLast) begin
                    cnt_d = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == BaudLast) begin
                    cnt_d = '0;
                    par_bad_d = (rx_s != ^shift_q);
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (cnt_q == BaudLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            err_d = 1'b1;
                        end else begin
                            stb_d  = 1'b1;
                            data_d = shift_q;
                        end
`else
                        stb_d  = 1'b1;
                        data_d = shift_q;
`endif
                    end else begin
                        err_d   = 1'b1;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    assign rx_stb_o  = stb_q;
    assign rx_data_o = data_q;
    assign rx_err_o  = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 ticks per bit.
// Frames carry an even-parity bit when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int Tpb = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LatNom = 171;
`else
    localparam int LatNom = 155;
`endif

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       stb;
    logic [7:0] data;
    logic       err;

    int cmp_cnt = 0;
    int mis_cnt = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int cyc = 0;
    int stb_cyc = 0;
    int start_cyc = 0;
    logic [7:0] log_q[$];

    uart_rx #(
        .TicksPerBaud(Tpb)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .rx_i     (rx),
        .rx_stb_o (stb),
        .rx_data_o(data),
        .rx_err_o (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (stb) begin
                stb_cnt <= stb_cnt + 1;
                stb_cyc <= cyc;
                log_q.push_back(data);
            end
            if (err) err_cnt <= err_cnt + 1;
            if (stb && err) both_cnt <= both_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp)
        else begin
            mis_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic line_bit(input logic v);
        rx = v;
        repeat (Tpb) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input logic par_flip);
        start_cyc = cyc;
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        line_bit(^d ^ par_flip);
`else
        if (par_flip) line_bit(1'b1);
`endif
        line_bit(stop_v);
    endtask

    int s0, e0;

    initial begin
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_data", 32'(data), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (100) @(negedge clk);
        chk("idle_stb", stb_cnt, 0);
        chk("idle_err", err_cnt, 0);
        chk("idle_data", 32'(data), 32'h00);

        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("a5_cnt", stb_cnt, 1);
        chk("a5_data", 32'(log_q[0]), 32'hA5);
        chk("a5_err", err_cnt, 0);
        chk("a5_lat", 32'((stb_cyc - start_cyc >= LatNom - 5) &&
                          (stb_cyc - start_cyc <= LatNom + 5)), 32'd1);

        line_bit(1'b1);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        line_bit(1'b1);
        chk("b2b_cnt", stb_cnt, 3);
        chk("b2b_d0", 32'(log_q[1]), 32'h00);
        chk("b2b_d1", 32'(log_q[2]), 32'hFF);

        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (5 * Tpb) @(negedge clk);
        chk("glitch_stb", stb_cnt, 3);
        chk("glitch_err", err_cnt, 0);

        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40) line_bit(1'b0);
        repeat (3) line_bit(1'b1);
        chk("brk_err", err_cnt, 1);
        chk("brk_stb", stb_cnt, 3);
        send_frame(8'h01, 1'b1, 1'b0);
        line_bit(1'b1);
        chk("post_brk_cnt", stb_cnt, 4);
        chk("post_brk_data", 32'(log_q[3]), 32'h01);

        line_bit(1'b0);
        line_bit(1'b1);
        line_bit(1'b0);
        line_bit(1'b1);
        rx = 1'b0;
        repeat (Tpb / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stb", 32'(stb), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_data", 32'(data), 32'h00);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) line_bit(1'b1);
        chk("mid_rst_none", stb_cnt, 4);
        chk("mid_rst_noerr", err_cnt, 1);
        send_frame(8'h55, 1'b1, 1'b0);
        line_bit(1'b1);
        chk("r55_cnt", stb_cnt, 5);
        chk("r55_data", 32'(log_q[4]), 32'h55);

`ifdef UART_RX_PARITY_EN
        s0 = stb_cnt;
        e0 = err_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        line_bit(1'b1);
        chk("par_bad_err", err_cnt, e0 + 1);
        chk("par_bad_stb", stb_cnt, s0);
        send_frame(8'h07, 1'b1, 1'b0);
        line_bit(1'b1);
        chk("par_ok_stb", stb_cnt, s0 + 1);
        chk("par_ok_data", 32'(data), 32'h07);
        chk("par_ok_err", err_cnt, e0 + 1);
`endif

        chk("never_both", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
